store_drain_unit: RTL
=====================

// Module: store_drain_unit
// PURPOSE
//  Memory-side consumer of the store pipeline stage. Accepts store and fence requests
//  via valid/ready, buffers stores in a DEPTH-entry FIFO, converts each to a lane-aligned
//  64-bit write (byte strobes) and drains them to data memory over a req/gnt bus.
//  A fence holds off new requests until every buffered store is granted, then pulses done.
// PARAMETERS
//  XLEN   64  data/address width (fixed at 64; strobe logic assumes 8 byte lanes)
//  DEPTH  4   store FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  st_valid    in   1      store-stage request valid
//  st_ready    out  1      request accepted this cycle when st_valid & st_ready
//  st_addr     in   XLEN   byte address
//  st_data     in   XLEN   store data, right-justified
//  st_we       in   1      1 = store, 0 = no memory write
//  st_size     in   2      0 byte, 1 half, 2 word, 3 dword
//  fence_sig   in   8      nonzero = fence request (pred/succ bits)
//  fence_mode  in   4      fence mode; passed to fence_mode_q, no effect on ordering
//  mem_req     out  1      write request to memory
//  mem_gnt     in   1      memory accepts head entry this cycle (mem_req & mem_gnt)
//  mem_addr    out  XLEN   {head_addr[XLEN-1:3], 3'b000}
//  mem_wdata   out  XLEN   lane-aligned write data
//  mem_wstrb   out  8      byte-lane strobes
//  fence_done  out  1      one-cycle pulse when a fence completes
//  fence_mode_q out 4      fence_mode of the fence in progress or last completed
//  misalign_err out 1      one-cycle pulse: misaligned store dropped
//  buf_count   out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO emptied; state RUN; fence_done=0; misalign_err=0;
//   fence_mode_q=0; buf_count=0. Hence mem_req=0, mem_addr/wdata/wstrb=0 and st_ready=1.
//   Reset mid-drain discards all buffered stores and any fence in progress; no fence_done.
//  st_ready = (state==RUN) & (buf_count!=DEPTH). No bypass: full FIFO stalls even if popping.
//  Accept (st_valid & st_ready):
//   - st_we=1, aligned: push {addr,wdata,wstrb} into FIFO.
//   - st_we=1, misaligned (addr[size-1:0]!=0): not pushed; misalign_err=1 next cycle.
//   - st_we=0: no push (no-op).
//   - fence_sig!=0: store handling above (if st_we=1) happens first, then state->DRAIN,
//     fence_mode_q<=fence_mode.
//  Lane alignment (at push): sh = addr[2:0]*8; wdata = st_data << sh (truncated to 64b);
//   wstrb: size0 8'h01<<addr[2:0]; size1 8'h03<<addr[2:0]; size2 8'h0F<<addr[2:0]; size3 8'hFF.
//  Drain: mem_req = (buf_count!=0); mem_addr/wdata/wstrb = head entry, held stable while
//   mem_req & ~mem_gnt. On mem_req & mem_gnt: pop, head advances next cycle.
//  Push and pop same cycle: buf_count unchanged; pointers wrap modulo DEPTH.
//  mem_addr/wdata/wstrb are 0 when FIFO empty.
//  FSM: RUN -> DRAIN on fence accept. DRAIN -> DONE when buf_count==0 (after the last pop,
//   or immediately the next cycle if already empty). DONE: fence_done=1 one cycle -> RUN.
//   Minimum fence latency: accept cycle + 2 cycles to fence_done; st_ready=0 in DRAIN/DONE.
// TESTING
//  1. Push sb addr 0x1003 data 0xAB, mem_gnt=1 -> mem_addr 0x1000, wstrb 0x08,
//     wdata 0x0000_0000_AB00_0000, buf_count back to 0.
//  2. Four sd pushes with mem_gnt=0 -> buf_count=4, st_ready=0; raise gnt -> 4 writes in order,
//     head held stable during stall.
//  3. sw addr 0x1006 -> no mem_req, misalign_err pulses 1 cycle, buf_count stays 0.
//  4. Two stores then fence_sig=8'h33 fence_mode=4'h0 with gnt delayed 5 cycles ->
//     st_ready=0 until fence_done pulses once after second grant; then st_ready=1.
//  5. Fence on empty FIFO -> fence_done exactly 2 cycles after accept; fence_mode_q = input.
//  6. rst=1 with 3 entries buffered and fence pending -> next cycle buf_count=0, mem_req=0,
//     st_ready=1, no fence_done.

Source files
------------

// File: rtl/store_drain_unit.sv
// rtl/store_drain_unit.sv - store/fence request buffer draining lane-aligned writes to memory
module store_drain_unit #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [XLEN-1:0]            st_addr,
  input  logic [XLEN-1:0]            st_data,
  input  logic                       st_we,
  input  logic [1:0]                 st_size,
  input  logic [7:0]                 fence_sig,
  input  logic [3:0]                 fence_mode,
  output logic                       mem_req,
  input  logic                       mem_gnt,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [7:0]                 mem_wstrb,
  output logic                       fence_done,
  output logic [3:0]                 fence_mode_q,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            fence_done_q, misalign_err_q;
  logic [3:0]      fence_mode_r_q;
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [7:0]      strb_mem [DEPTH];

  logic            misaligned, accept, push, pop;
  logic [7:0]      lane_strb;
  logic [XLEN-1:0] lane_data;

  always_comb begin
    misaligned = 1'b0;
    lane_strb  = 8'h00;
    case (st_size)
      2'd0: begin misaligned = 1'b0;            lane_strb = 8'h01 << st_addr[2:0]; end
      2'd1: begin misaligned = st_addr[0];      lane_strb = 8'h03 << st_addr[2:0]; end
      2'd2: begin misaligned = |st_addr[1:0];   lane_strb = 8'h0F << st_addr[2:0]; end
      default: begin misaligned = |st_addr[2:0]; lane_strb = 8'hFF; end
    endcase
  end

  assign lane_data = st_data << {st_addr[2:0], 3'b000};
  assign st_ready  = (state_q == RUN) && (count_q != CW'(DEPTH));
  assign accept    = st_valid & st_ready;
  assign push      = accept & st_we & ~misaligned;
  assign mem_req   = (count_q != '0);
  assign pop       = mem_req & mem_gnt;

  // Head is forced to zero while empty so the bus never shows stale entries.
  assign mem_addr  = mem_req ? addr_mem[rd_ptr_q] : '0;
  assign mem_wdata = mem_req ? data_mem[rd_ptr_q] : '0;
  assign mem_wstrb = mem_req ? strb_mem[rd_ptr_q] : '0;

  assign fence_done   = fence_done_q;
  assign misalign_err = misalign_err_q;
  assign fence_mode_q = fence_mode_r_q;
  assign buf_count    = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= {st_addr[XLEN-1:3], 3'b000};
      data_mem[wr_ptr_q] <= lane_data;
      strb_mem[wr_ptr_q] <= lane_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      fence_done_q   <= 1'b0;
      misalign_err_q <= 1'b0;
      fence_mode_r_q <= 4'h0;
    end else begin
      fence_done_q   <= 1'b0;
      misalign_err_q <= accept & st_we & misaligned;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      case (state_q)
        RUN: begin
          if (accept && (fence_sig != 8'h00)) begin
            state_q        <= DRAIN;
            fence_mode_r_q <= fence_mode;
          end
        end
        DRAIN: begin
          if (count_q == '0) begin
            state_q      <= DONE;
            fence_done_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end
endmodule
